// File: rtl/arb_mux_n.sv
// N-input registered selector with valid/ready handshakes.
// One channel per cycle is chosen by explicit sel (MODE 0) or round-robin (MODE 1).
module arb_mux_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]      out_data_reg;
  logic [SEL_W-1:0]      out_src_reg;
  logic                  out_valid_reg;
  logic [SEL_W-1:0]      last_reg;

  logic                  load_en;
  logic [WIDTH-1:0]      ch_data [NUM_IN];
  logic [NUM_IN-1:0]     gnt_onehot;
  logic [SEL_W-1:0]      gnt;
  logic                  gnt_found;
  logic [SEL_W-1:0]      rr_gnt;
  logic                  rr_found;
  logic [NUM_IN-1:0]     rr_rot;
  logic [2*NUM_IN-1:0]   valid_dbl;
  logic                  sel_ok;
  logic                  xfer;
  logic [WIDTH-1:0]      gnt_data;
  int                    rr_sum;

  assign load_en   = !out_valid_reg || out_ready;
  assign sel_ok    = int'(sel) < NUM_IN;
  assign valid_dbl = {in_valid, in_valid};

  // Rotate so bit 0 is the channel right after the last winner, then pick the lowest set bit.
  always_comb begin
    rr_rot   = NUM_IN'(valid_dbl >> (int'(last_reg) + 1));
    rr_found = 1'b0;
    rr_gnt   = last_reg;
    rr_sum   = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!rr_found && rr_rot[i]) begin
        rr_found = 1'b1;
        rr_sum   = int'(last_reg) + 1 + i;
        if (rr_sum >= NUM_IN) rr_sum = rr_sum - NUM_IN;
        rr_gnt   = SEL_W'(rr_sum);
      end
    end
  end

  always_comb begin
    if (MODE == 0) begin
      gnt       = sel;
      gnt_found = sel_ok;
    end else begin
      gnt       = rr_gnt;
      gnt_found = rr_found;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
      assign ch_data[gi]    = in_data[gi*WIDTH +: WIDTH];
      assign gnt_onehot[gi] = gnt_found && (gnt == SEL_W'(gi));
      assign in_ready[gi]   = rst_n && load_en && gnt_onehot[gi];
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_onehot[i]) gnt_data = ch_data[i];
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      last_reg      <= SEL_W'(NUM_IN - 1);
    end else begin
      if (load_en) begin
        if (xfer) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= gnt_data;
          out_src_reg   <= gnt;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
      // Pointer only advances on a real handshake so a stalled winner keeps its turn.
      if (MODE != 0 && xfer) last_reg <= gnt;
    end
  end

  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: explicit-select (4 and 3 channels) and round-robin (4 channels)
// instances, checked every cycle against a behavioural model plus directed expectations.
module tb_arb_mux_n;

  logic       clk;
  logic       rstn [3];
  logic [4:0] dat  [3][4];
  logic [3:0] vld  [3];
  logic [1:0] sl   [3];
  logic       ordy [3];

  logic [3:0] rdy0, rdy1;
  logic [2:0] rdy2;
  logic [3:0] a_rdy [3];
  logic [4:0] od [3];
  logic [1:0] os [3];
  logic       ov [3];

  logic [19:0] pk0, pk1;
  logic [14:0] pk2;
  logic [2:0]  v2;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  // model state
  logic       mv [3];
  logic [4:0] md [3];
  logic [1:0] msrc [3];
  int         mlast [3];

  logic [3:0] tv [10];
  logic       tr [10];
  logic [1:0] ts [10];

  assign pk0 = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign pk1 = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
  assign pk2 = {dat[2][2], dat[2][1], dat[2][0]};
  assign v2  = vld[2][2:0];
  assign a_rdy[0] = rdy0;
  assign a_rdy[1] = rdy1;
  assign a_rdy[2] = {1'b0, rdy2};

  arb_mux_n #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rstn[0]), .in_data(pk0), .in_valid(vld[0]), .in_ready(rdy0),
    .sel(sl[0]), .out_data(od[0]), .out_src(os[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

  arb_mux_n #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .MODE(1)) u1 (
    .clk(clk), .rst_n(rstn[1]), .in_data(pk1), .in_valid(vld[1]), .in_ready(rdy1),
    .sel(sl[1]), .out_data(od[1]), .out_src(os[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

  arb_mux_n #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .MODE(0)) u2 (
    .clk(clk), .rst_n(rstn[2]), .in_data(pk2), .in_valid(v2), .in_ready(rdy2),
    .sel(sl[2]), .out_data(od[2]), .out_src(os[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int d, input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Model: at each falling edge, predict in_ready from current inputs, compare, then
  // advance to the state the rising edge will produce.
  always @(negedge clk) begin
    int n, g, c;
    bit has, ld, xf, rr;
    logic [3:0] er;
    for (int d = 0; d < 3; d++) begin
      n   = (d == 2) ? 3 : 4;
      rr  = (d == 1);
      has = 1'b0;
      g   = 0;
      ld  = !mv[d] || ordy[d];
      if (!rr) begin
        if (int'(sl[d]) < n) begin
          has = 1'b1;
          g   = int'(sl[d]);
        end
      end else begin
        for (int k = 1; k <= n; k++) begin
          c = (mlast[d] + k) % n;
          if (!has && vld[d][c]) begin
            has = 1'b1;
            g   = c;
          end
        end
      end
      er = (rstn[d] && ld && has) ? 4'(1 << g) : 4'b0;
      if (ncyc > 0) begin
        chk(d, "m_in_ready",  8'(a_rdy[d]), 8'(er));
        chk(d, "m_out_valid", 8'(ov[d]),    8'(mv[d]));
        chk(d, "m_out_data",  8'(od[d]),    8'(md[d]));
        chk(d, "m_out_src",   8'(os[d]),    8'(msrc[d]));
      end
      if (!rstn[d]) begin
        mv[d] = 1'b0; md[d] = 5'd0; msrc[d] = 2'd0; mlast[d] = n - 1;
      end else begin
        xf = ld && has && vld[d][g];
        if (ld) begin
          if (xf) begin
            mv[d] = 1'b1; md[d] = dat[d][g]; msrc[d] = 2'(g);
          end else begin
            mv[d] = 1'b0;
          end
        end
        if (xf && rr) mlast[d] = g;
      end
    end
    ncyc++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv = '{4'h6, 4'h6, 4'h6, 4'h1, 4'h9, 4'h0, 4'hF, 4'hF, 4'h4, 4'h0};
    tr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ts = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1};
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; vld[d] = 4'hF; ordy[d] = 1'b1; sl[d] = 2'd0;
      for (int i = 0; i < 4; i++) dat[d][i] = 5'(i + 1);
    end

    // 1: reset held 3 cycles with everything asserted
    repeat (3) begin
      cyc();
      for (int d = 0; d < 3; d++) begin
        chk(d, "rst_valid", 8'(ov[d]), 8'h00);
        chk(d, "rst_data",  8'(od[d]), 8'h00);
        chk(d, "rst_src",   8'(os[d]), 8'h00);
        chk(d, "rst_ready", 8'(a_rdy[d]), 8'h00);
      end
    end
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b1; vld[d] = 4'h0;
    end
    cyc();

    // 2: explicit select of channel 2
    sl[0] = 2'd2; dat[0][2] = 5'h15; vld[0] = 4'b0100;
    #1 chk(0, "t2_ready", 8'(a_rdy[0]), 8'h04);
    cyc();
    chk(0, "t2_valid", 8'(ov[0]), 8'h01);
    chk(0, "t2_data",  8'(od[0]), 8'h15);
    chk(0, "t2_src",   8'(os[0]), 8'h02);

    // 3: backpressure freezes the stage regardless of sel/data
    ordy[0] = 1'b0; vld[0] = 4'hF; dat[0][2] = 5'h0B;
    for (int k = 0; k < 5; k++) begin
      sl[0] = 2'(k);
      #1 chk(0, "t3_ready", 8'(a_rdy[0]), 8'h00);
      cyc();
      chk(0, "t3_data",  8'(od[0]), 8'h15);
      chk(0, "t3_src",   8'(os[0]), 8'h02);
      chk(0, "t3_valid", 8'(ov[0]), 8'h01);
    end
    ordy[0] = 1'b1; sl[0] = 2'd1; dat[0][1] = 5'h0A;
    #1 chk(0, "t3_reload_ready", 8'(a_rdy[0]), 8'h02);
    cyc();
    chk(0, "t3_reload_data", 8'(od[0]), 8'h0A);
    chk(0, "t3_reload_src",  8'(os[0]), 8'h01);
    vld[0] = 4'h0;

    // 4: round-robin fairness with all channels requesting
    for (int i = 0; i < 4; i++) dat[1][i] = 5'(16 + i);
    vld[1] = 4'hF;
    #1 chk(1, "t4_first_ready", 8'(a_rdy[1]), 8'h01);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk(1, "t4_src",   8'(os[1]), 8'(k % 4));
      chk(1, "t4_data",  8'(od[1]), 8'(16 + k % 4));
      chk(1, "t4_valid", 8'(ov[1]), 8'h01);
      chk(1, "t4_ready", 8'(a_rdy[1]), 8'(1 << ((k + 1) % 4)));
    end

    // 5: wrap with only channels 1 and 3 requesting, pointer at 3
    vld[1] = 4'b1010;
    #1 chk(1, "t5_ready_a", 8'(a_rdy[1]), 8'h02);
    cyc();
    chk(1, "t5_src_a", 8'(os[1]), 8'h01);
    chk(1, "t5_ready_b", 8'(a_rdy[1]), 8'h08);
    cyc();
    chk(1, "t5_src_b", 8'(os[1]), 8'h03);
    chk(1, "t5_ready_c", 8'(a_rdy[1]), 8'h02);
    cyc();
    chk(1, "t5_src_c", 8'(os[1]), 8'h01);
    vld[1] = 4'h0;

    // mixed valid/backpressure vectors, checked by the model only
    for (int i = 0; i < 10; i++) begin
      vld[0] = tv[i]; vld[1] = tv[i];
      ordy[0] = tr[i]; ordy[1] = tr[i];
      sl[0] = ts[i];
      for (int j = 0; j < 4; j++) begin
        dat[0][j] = 5'(i * 3 + j);
        dat[1][j] = 5'(31 - i * 2 - j);
      end
      cyc();
    end
    vld[0] = 4'h0; vld[1] = 4'h0; ordy[0] = 1'b1; ordy[1] = 1'b1;
    cyc();

    // 6: three-channel instance, out-of-range sel, reset while holding data
    sl[2] = 2'd0; dat[2][0] = 5'h07; vld[2] = 4'b0001;
    #1 chk(2, "t6_ready_a", 8'(a_rdy[2]), 8'h01);
    cyc();
    chk(2, "t6_valid_a", 8'(ov[2]), 8'h01);
    chk(2, "t6_data_a",  8'(od[2]), 8'h07);
    sl[2] = 2'd3;
    #1 chk(2, "t6_ready_oor", 8'(a_rdy[2]), 8'h00);
    cyc();
    chk(2, "t6_valid_drain", 8'(ov[2]), 8'h00);
    chk(2, "t6_data_keep",   8'(od[2]), 8'h07);
    sl[2] = 2'd1; dat[2][1] = 5'h1C; vld[2] = 4'b0010;
    cyc();
    chk(2, "t6_valid_b", 8'(ov[2]), 8'h01);
    chk(2, "t6_data_b",  8'(od[2]), 8'h1C);
    chk(2, "t6_src_b",   8'(os[2]), 8'h01);
    ordy[2] = 1'b0; rstn[2] = 1'b0;
    #1 chk(2, "t6_ready_rst", 8'(a_rdy[2]), 8'h00);
    cyc();
    chk(2, "t6_valid_rst", 8'(ov[2]), 8'h00);
    chk(2, "t6_data_rst",  8'(od[2]), 8'h00);
    chk(2, "t6_src_rst",   8'(os[2]), 8'h00);
    rstn[2] = 1'b1; vld[2] = 4'h0; ordy[2] = 1'b1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
